// File: rtl/peaton_control.sv
// peaton_control: pedestrian-crossing controller downstream of the vehicle light controller.
// Grants a timed walk phase (guard, steady green, flashing green) only inside a vehicle
// red phase. Forces pedestrians to stop when vehicle red ends or the lights become illegal.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   r, a, v    registered vehicle red/amber/green from the upstream controller
//   boton      raw asynchronous pedestrian push-button
//   p_rojo     pedestrian "don't walk" lamp
//   p_verde    pedestrian "walk" lamp
//   solicitud  request-pending indicator
//   corte      one-cycle pulse when a guard/walk/blink phase is aborted
//   falla      high while the vehicle light combination is illegal
//   beep       audible pulse (only with PEATON_BEEP_EN defined, otherwise 0)
//
// Optional feature macro: PEATON_BEEP_EN
module peaton_control #(
   parameter int unsigned DEB_CYC    = 4,
   parameter int unsigned GUARD_CYC  = 10,
   parameter int unsigned WALK_CYC   = 120,
   parameter int unsigned BLINK_CYC  = 40,
   parameter int unsigned BLINK_HALF = 5,
   parameter int unsigned BEEP_PER   = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic r,
   input  logic a,
   input  logic v,
   input  logic boton,
   output logic p_rojo,
   output logic p_verde,
   output logic solicitud,
   output logic corte,
   output logic falla,
   output logic beep
);

   localparam logic [7:0] DebLast       = 8'(DEB_CYC - 1);
   localparam logic [7:0] DebSat        = 8'(DEB_CYC);
   localparam logic [7:0] GuardLast     = 8'(GUARD_CYC - 1);
   localparam logic [7:0] WalkLast      = 8'(WALK_CYC - 1);
   localparam logic [7:0] BlinkLast     = 8'(BLINK_CYC - 1);
   localparam logic [7:0] BlinkHalfLast = 8'(BLINK_HALF - 1);

   typedef enum logic [2:0] {StIdle, StGuard, StWalk, StBlink, StFault} state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       sync1_q, sync2_q;
   logic [7:0] deb_q;
   logic       r_q;
   logic       sol_q, sol_d;
   logic       abort_q, abort_d;
   logic [7:0] half_q;
   logic       phase_q;
   logic       p_rojo_q, p_verde_q, sol_out_q, corte_q, falla_q;

   logic accept, r_ini, legal, clr_sol;

   // Debounce counter saturates at DEB_CYC, so a held button yields a single accept.
   assign accept = sync2_q && (deb_q == DebLast);
   assign r_ini  = r && !r_q;
   assign legal  = ({r, a, v} == 3'b100) || ({r, a, v} == 3'b010) || ({r, a, v} == 3'b001);

   always_comb begin
      state_d = state_q;
      abort_d = 1'b0;
      clr_sol = 1'b0;
      if (!legal) begin
         state_d = StFault;
      end else begin
         unique case (state_q)
            StIdle:  if (r_ini && (sol_q || accept)) state_d = StGuard;
            StGuard: begin
               if (!r) begin
                  state_d = StIdle;
                  abort_d = 1'b1;
               end else if (cnt_q == GuardLast) begin
                  state_d = StWalk;
                  clr_sol = 1'b1;
               end
            end
            StWalk: begin
               if (!r) begin
                  state_d = StIdle;
                  abort_d = 1'b1;
               end else if (cnt_q == WalkLast) begin
                  state_d = StBlink;
               end
            end
            StBlink: begin
               if (!r) begin
                  state_d = StIdle;
                  abort_d = 1'b1;
               end else if (cnt_q == BlinkLast) begin
                  state_d = StIdle;
               end
            end
            StFault: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
      cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
      // A press accepted on the walk-entry edge still counts for the next red phase.
      sol_d = accept || (sol_q && !clr_sol);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 8'd0;
         r_q       <= 1'b0;
         sol_q     <= 1'b0;
         abort_q   <= 1'b0;
         half_q    <= 8'd0;
         phase_q   <= 1'b1;
         p_rojo_q  <= 1'b1;
         p_verde_q <= 1'b0;
         sol_out_q <= 1'b0;
         corte_q   <= 1'b0;
         falla_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sync1_q <= boton;
         sync2_q <= sync1_q;
         if (!sync2_q)          deb_q <= 8'd0;
         else if (deb_q != DebSat) deb_q <= deb_q + 8'd1;
         r_q     <= r;
         sol_q   <= sol_d;
         abort_q <= abort_d;
         // Flash phase restarts lit on every blink entry.
         if (state_q != StBlink) begin
            half_q  <= 8'd0;
            phase_q <= 1'b1;
         end else if (half_q == BlinkHalfLast) begin
            half_q  <= 8'd0;
            phase_q <= !phase_q;
         end else begin
            half_q <= half_q + 8'd1;
         end
         p_rojo_q  <= (state_q == StIdle) || (state_q == StGuard) || (state_q == StFault);
         p_verde_q <= (state_q == StWalk) || ((state_q == StBlink) && phase_q);
         sol_out_q <= sol_q;
         corte_q   <= abort_q;
         falla_q   <= (state_q == StFault);
      end
   end

   assign p_rojo    = p_rojo_q;
   assign p_verde   = p_verde_q;
   assign solicitud = sol_out_q;
   assign corte     = corte_q;
   assign falla     = falla_q;

`ifdef PEATON_BEEP_EN
   localparam int unsigned BeepBlinkPer  = (BEEP_PER / 4 > 0) ? BEEP_PER / 4 : 1;
   localparam logic [7:0]  BeepWalkLast  = 8'(BEEP_PER - 1);
   localparam logic [7:0]  BeepBlinkLast = 8'(BeepBlinkPer - 1);

   logic [7:0] bcnt_q;
   logic       beep_q;
   logic       beep_act;
   logic [7:0] beep_last;

   always_comb begin
      beep_act  = (state_q == StWalk) || (state_q == StBlink);
      beep_last = (state_q == StBlink) ? BeepBlinkLast : BeepWalkLast;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q <= 8'd0;
         beep_q <= 1'b0;
      end else begin
         beep_q <= beep_act && (bcnt_q == beep_last);
         if (!beep_act || (state_d != state_q) || (bcnt_q == beep_last)) bcnt_q <= 8'd0;
         else                                                         bcnt_q <= bcnt_q + 8'd1;
      end
   end

   assign beep = beep_q;
`else
   assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_peaton_control.sv
// Self-checking bench for peaton_control: expected output values are queued with the
// edge index at which they must appear and compared on the following falling edge.
module tb_peaton_control;

   logic clk = 1'b0;
   logic rst, r, a, v, boton;
   logic p_rojo, p_verde, solicitud, corte, falla, beep;
   logic [5:0] obs;

   localparam logic [5:0] MRojo  = 6'b100000;
   localparam logic [5:0] MVerde = 6'b010000;
   localparam logic [5:0] MSol   = 6'b001000;
   localparam logic [5:0] MCorte = 6'b000100;
   localparam logic [5:0] MFalla = 6'b000010;
   localparam logic [5:0] MBeep  = 6'b000001;

`ifdef PEATON_BEEP_EN
   localparam int ExpBeepWalk  = 6;  // 120 walk cycles / 20
   localparam int ExpBeepBlink = 8;  // 40 blink cycles / 5
`else
   localparam int ExpBeepWalk  = 0;
   localparam int ExpBeepBlink = 0;
`endif

   typedef struct {
      int         cyc;
      string      tag;
      logic [5:0] mask;
      logic [5:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   wlo = -1, whi = -1, blo = -1, bhi = -1;
   int   nbw = 0, nbb = 0;
   int   t, n0, l0, k0, m0, f0, r0;

   peaton_control dut (
      .clk       (clk),
      .rst       (rst),
      .r         (r),
      .a         (a),
      .v         (v),
      .boton     (boton),
      .p_rojo    (p_rojo),
      .p_verde   (p_verde),
      .solicitud (solicitud),
      .corte     (corte),
      .falla     (falla),
      .beep      (beep)
   );

   assign obs = {p_rojo, p_verde, solicitud, corte, falla, beep};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, expv, cyc);
      end
   endtask

   function automatic void push(input int c, input string tag, input logic [5:0] m,
                                input logic [5:0] val);
      exp_t e;
      int   i;
      e.cyc  = c;
      e.tag  = tag;
      e.mask = m;
      e.val  = val;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endfunction

   // Scoreboard consumer and beep window counters.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc < cyc) check_val({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
         else             check_val(e.tag, {26'd0, obs & e.mask}, {26'd0, e.val & e.mask});
      end
      if (beep && cyc >= wlo && cyc <= whi) nbw++;
      if (beep && cyc >= blo && cyc <= bhi) nbb++;
   end

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic lights(input logic [2:0] x);
      {r, a, v} = x;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; boton = 1'b0; lights(3'b000);
      adv(2);
      check_val("reset_outs", {26'd0, obs}, {26'd0, MRojo});

      // Power-up with upstream 000: one FAULT cycle.
      rst = 1'b0;
      t = cyc;
      push(t + 1, "pwr_falla0", MFalla, 6'b0);
      push(t + 2, "pwr_falla1", MFalla | MRojo, MFalla | MRojo);
      push(t + 3, "pwr_falla_clr", MFalla, 6'b0);
      adv(1);
      lights(3'b001);
      adv(4);

      // Debounce: 3-cycle pulse ignored, 6-cycle hold accepted.
      t = cyc;
      push(t + 6, "deb_short", MSol, 6'b0);
      push(t + 10, "deb_short2", MSol, 6'b0);
      boton = 1'b1; adv(3); boton = 1'b0;
      adv(8);
      t = cyc;
      push(t + 6, "deb_hold_early", MSol, 6'b0);
      push(t + 7, "deb_hold_set", MSol, MSol);
      push(t + 12, "deb_keep", MSol, MSol);
      boton = 1'b1; adv(6); boton = 1'b0;
      adv(8);

      // Full crossing, red held 200 cycles.
      lights(3'b010); adv(3); lights(3'b100);
      n0 = cyc + 1;
      wlo = n0 + 11; whi = n0 + 130; blo = n0 + 131; bhi = n0 + 170;
      push(n0, "guard_pre", MRojo | MVerde, MRojo);
      push(n0 + 5, "guard_beep", MBeep | MVerde, 6'b0);
      push(n0 + 10, "guard_end", MRojo | MVerde | MSol, MRojo | MSol);
      push(n0 + 11, "walk_first", MRojo | MVerde | MSol, MVerde);
      push(n0 + 70, "walk_mid", MRojo | MVerde, MVerde);
      push(n0 + 130, "walk_last", MRojo | MVerde, MVerde);
      for (int k = 0; k < 40; k++)
         push(n0 + 131 + k, "blink", MRojo | MVerde, ((k / 5) % 2 == 0) ? MVerde : 6'b0);
      push(n0 + 171, "after_blink", MRojo | MVerde | MCorte | MBeep, MRojo);
      push(n0 + 199, "red_idle", MRojo | MVerde, MRojo);
      push(n0 + 201, "no_corte", MCorte | MRojo, MRojo);
      adv(200);
      lights(3'b001);
      adv(3);
      check_val("beep_walk", 32'(nbw), 32'(ExpBeepWalk));
      check_val("beep_blink", 32'(nbb), 32'(ExpBeepBlink));

      // Late request: accepted 20 cycles into red, no walk in this phase.
      adv(17);
      lights(3'b010); adv(3); lights(3'b100);
      l0 = cyc + 1;
      push(l0 + 11, "late_nowalk", MRojo | MVerde, MRojo);
      push(l0 + 20, "late_sol0", MSol, 6'b0);
      push(l0 + 21, "late_sol1", MSol, MSol);
      push(l0 + 40, "late_nowalk2", MRojo | MVerde, MRojo);
      push(l0 + 59, "late_endred", MRojo | MVerde | MSol, MRojo | MSol);
      adv(15);
      boton = 1'b1; adv(8); boton = 1'b0;
      adv(37);
      lights(3'b001);

      // Next red phase walks, then abort mid-walk.
      adv(10);
      lights(3'b010); adv(3); lights(3'b100);
      k0 = cyc + 1;
      m0 = k0 + 41;
      push(k0 + 10, "next_guard", MVerde | MSol, MSol);
      push(k0 + 11, "next_walk", MRojo | MVerde | MSol, MVerde);
      push(m0, "abort_pre", MVerde | MCorte, MVerde);
      push(m0 + 1, "abort", MRojo | MVerde | MCorte, MRojo | MCorte);
      push(m0 + 2, "abort_clr", MRojo | MCorte, MRojo);
      push(m0 + 5, "abort_stay", MRojo | MVerde, MRojo);
      adv(41);
      lights(3'b001);
      adv(8);

      // Fault with pending request retained.
      boton = 1'b1; adv(8); boton = 1'b0;
      adv(4);
      f0 = cyc;
      push(f0 + 1, "flt_pre", MFalla, 6'b0);
      push(f0 + 2, "flt_1", MFalla | MRojo | MVerde, MFalla | MRojo);
      push(f0 + 3, "flt_2", MFalla, MFalla);
      push(f0 + 4, "flt_3", MFalla | MSol, MFalla | MSol);
      push(f0 + 5, "flt_clr", MFalla | MSol, MSol);
      push(f0 + 10, "flt_sol", MSol | MRojo | MVerde, MSol | MRojo);
      lights(3'b101); adv(3); lights(3'b001);
      adv(8);

      // Walk from retained request, new press during walk, then async reset.
      lights(3'b010); adv(3); lights(3'b100);
      r0 = cyc + 1;
      push(r0 + 11, "rwalk", MRojo | MVerde, MVerde);
      push(r0 + 19, "walk_req", MSol | MVerde, MSol | MVerde);
      adv(13);
      boton = 1'b1; adv(8);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_val("rst_async", {26'd0, obs & (MRojo | MVerde | MSol)}, {26'd0, MRojo});
      boton = 1'b0;
      lights(3'b001);
      adv(2);
      rst = 1'b0;
      adv(3);

      check_val("sb_drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/peaton_control.md
# peaton_control

Pedestrian-crossing controller that sits directly downstream of the vehicle traffic-light controller. It consumes that controller's registered vehicle lights `r`, `a` and `v` together with a raw pedestrian push-button. It drives the pedestrian red/green lamps, granting a timed walk phase only inside a vehicle red phase, and it forces pedestrians to stop whenever the vehicle lights leave red or become illegal. All timing is counted in `clk` cycles, on the same time base as the upstream controller.

## Interface
- `DEB_CYC`, 4: consecutive synchronized-high cycles required to accept a button press (1..255).
- `GUARD_CYC`, 10: all-red clearance cycles after vehicle red starts, before walk (1..255).
- `WALK_CYC`, 120: steady pedestrian-green cycles (1..255).
- `BLINK_CYC`, 40: flashing pedestrian-green cycles (1..255).
- `BLINK_HALF`, 5: half-period of the flash, in cycles (1..255).
- `BEEP_PER`, 20: beep pulse period during walk. Blink uses `BEEP_PER/4`, minimum 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `r`, `a`, `v`  in  1 each  vehicle red/amber/green from the upstream controller.
- `boton`  in  1  raw pedestrian button, asynchronous, active-high.
- `p_rojo`  out  1  pedestrian "don't walk" lamp.
- `p_verde`  out  1  pedestrian "walk" lamp.
- `solicitud`  out  1  request-pending indicator.
- `corte`  out  1  one-cycle pulse when a walk/guard phase is aborted.
- `falla`  out  1  high while the vehicle light combination is illegal.
- `beep`  out  1  audible-signal pulse (see Configuration).

## Operation
- **Button path**
  - `boton` passes through a 2-flop synchronizer, then a debounce counter.
  - A press is accepted when the synchronized level has been high for `DEB_CYC` consecutive cycles. This produces one accept event per press, with no re-trigger until the level returns low.
  - An accept event sets `solicitud`. It stays set until the WALK state is entered.
- **Red-phase tracking**
  - `r` is registered as `r_q`.
  - `r_ini = r & ~r_q` marks the start of a vehicle red phase.
- **Legality check**
  - `legal` = exactly one of `r`, `a`, `v` is high.
- **States:** IDLE, GUARD, WALK, BLINK, FAULT. Counter `cnt` is 8 bits and is cleared on every state change.
  - **Any state, `!legal`:** go to FAULT. This has highest priority.
  - **IDLE:** on `r_ini` with `solicitud`, or an accept event in the same cycle, go to GUARD. A request arriving after red has already started waits for the next red phase.
  - **GUARD:** after `GUARD_CYC` cycles, go to WALK and clear `solicitud`.
  - **WALK:** after `WALK_CYC` cycles, go to BLINK.
  - **BLINK:** after `BLINK_CYC` cycles, go to IDLE.
  - **GUARD, WALK or BLINK with `r`=0 (and `legal`):** go to IDLE and pulse `corte`.
  - **FAULT:** the first cycle with `legal`=1 goes to IDLE. A pending `solicitud` is kept.
  - An accept event during GUARD, WALK or BLINK sets `solicitud` for the next red phase.
- **Outputs per state**
  - IDLE and GUARD: `p_rojo`=1, `p_verde`=0.
  - WALK: `p_rojo`=0, `p_verde`=1.
  - BLINK: `p_rojo`=0. `p_verde` starts at 1 and toggles every `BLINK_HALF` cycles.
  - FAULT: `p_rojo`=1, `p_verde`=0, `falla`=1.
- **Invariant:** `p_verde` and `p_rojo` are never both 1. `p_verde`=1 only while the registered `r` was 1.

## Timing
- **Reset values:** state=IDLE, `p_rojo`=1, `p_verde`=0, `solicitud`=0, `corte`=0, `falla`=0, `beep`=0, `cnt`=0, synchronizer and debounce cleared. Reset applied mid-walk forces `p_verde`=0 immediately (asynchronous).
- **Output registration:** all outputs are registered and follow the state one cycle after the transition edge.
- **Button latency:** `boton` high sampled at edge 0 gives `solicitud`=1 after edge `DEB_CYC`+2, if held.
- **Walk timing:** with `r_ini` at edge N, `p_verde` rises at edge N+1+`GUARD_CYC`. Steady green lasts `WALK_CYC` cycles, then flashing lasts `BLINK_CYC` cycles.
- **Abort:** `r` falling at edge M gives `p_verde`=0, `p_rojo`=1 and `corte`=1 at edge M+1. `corte` returns to 0 at M+2.
- **Fault entry:** illegal input at edge M gives `falla`=1 at M+1.
- **Power-up:** the upstream 000 output at power-up enters FAULT for one cycle. This is expected behaviour.
- **Walk timing must fit:** `GUARD_CYC`+`WALK_CYC`+`BLINK_CYC` must be less than the upstream red length (200 cycles). The defaults give 170.

## Configuration
- **`PEATON_BEEP_EN` defined:**
  - `beep` pulses high for one cycle every `BEEP_PER` cycles in WALK.
  - `beep` pulses every `BEEP_PER/4` cycles in BLINK.
  - `beep` is 0 in all other states.
- **`PEATON_BEEP_EN` undefined:** `beep` is tied to 0 and the beep counter logic is not compiled.

## Test plan
- **Reset:** assert `rst` mid-walk, asynchronously → `p_verde`=0 and `p_rojo`=1 immediately; `solicitud`=0.
- **Debounce:** pulse `boton` for 3 cycles, then hold it for 6 cycles (`DEB_CYC`=4) → the 3-cycle pulse is ignored; `solicitud`=1 at 6 edges after the hold starts; exactly one accept event.
- **Full crossing:** `solicitud`=1, then `r` rises at edge 100 with `r`, `a`, `v` = 100 held for 200 cycles → `p_verde`=1 at edges 111–230, flashing at edges 231–270 (toggle every 5), then `p_rojo`=1; `solicitud` clears at edge 111.
- **Late request:** press accepted 20 cycles into red → no walk in this red phase; walk occurs in the next red phase.
- **Abort:** force `r`=0, `v`=1 during WALK → `p_verde`=0 and a one-cycle `corte` pulse at the next edge.
- **Fault and beep:** drive `r`=1, `v`=1 for 3 cycles → `falla`=1 for 3 cycles, then IDLE with `solicitud` retained. With `PEATON_BEEP_EN` defined, WALK shows a `beep` pulse every 20 cycles.
